// File: rtl/alu_cmd_ctrl.sv
// Initiator-side controller for the 8-bit combinational ALU: it buffers commands
// in a FIFO, drives each one onto the ALU for a single enable cycle, and returns the tagged result.
module alu_cmd_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic [3:0]       cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_en,
  input  logic [15:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [3:0]       rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [PTR_W:0]   cmd_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  state_e state_q, state_d;

  logic [7:0]       mem_a_q   [DEPTH];
  logic [7:0]       mem_b_q   [DEPTH];
  logic [3:0]       mem_sel_q [DEPTH];
  logic [3:0]       mem_tag_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic [7:0]  alu_a_q, alu_b_q;
  logic [3:0]  alu_sel_q, tag_q;
  logic        alu_en_q, err_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [15:0] rsp_data_q;
  logic [3:0]  rsp_tag_q;

  logic push, pop, head_err, rsp_hs;

  assign cmd_ready = (count_q < (PTR_W+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign head_err  = ((mem_sel_q[rd_ptr_q] == 4'd3) || (mem_sel_q[rd_ptr_q] == 4'd15))
                     && (mem_b_q[rd_ptr_q] == 8'd0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = RESP;
      RESP: begin
        if (rsp_hs) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_sel_q[i] <= '0;
        mem_tag_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_a_q[wr_ptr_q]   <= cmd_a;
        mem_b_q[wr_ptr_q]   <= cmd_b;
        mem_sel_q[wr_ptr_q] <= cmd_sel;
        mem_tag_q[wr_ptr_q] <= cmd_tag;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Response is captured at the end of the DRIVE cycle; err masks whatever the ALU
  // produced for a zero divisor so an undefined result never leaves this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_en_q    <= 1'b0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      alu_en_q <= pop;
      if (pop) begin
        alu_a_q   <= mem_a_q[rd_ptr_q];
        alu_b_q   <= mem_b_q[rd_ptr_q];
        alu_sel_q <= mem_sel_q[rd_ptr_q];
        tag_q     <= mem_tag_q[rd_ptr_q];
        err_q     <= head_err;
      end
      if (state_q == DRIVE) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= err_q ? 16'h0000 : alu_out;
        rsp_tag_q   <= tag_q;
        rsp_err_q   <= err_q;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign cmd_count = count_q;
  assign busy      = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural ALU attached to the ALU-side ports.
module tb_alu_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_sel, cmd_tag;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err, busy;
  logic [2:0]  cmd_count;

  int tests = 0;
  int fails = 0;

  alu_cmd_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_en(alu_en),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // ALU stand-in: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 15 MOD; a zero divisor yields junk.
  always_comb begin
    case (alu_sel)
      4'd0:    alu_out = {8'h00, alu_a} + {8'h00, alu_b};
      4'd1:    alu_out = {8'h00, alu_a} - {8'h00, alu_b};
      4'd2:    alu_out = {8'h00, alu_a} * {8'h00, alu_b};
      4'd3:    alu_out = (alu_b == 8'd0) ? 16'hDEAD : {8'h00, alu_a / alu_b};
      4'd15:   alu_out = (alu_b == 8'd0) ? 16'hDEAD : {8'h00, alu_a % alu_b};
      default: alu_out = {8'h00, alu_a ^ alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_tag   = tag;
  endtask

  // Single command from idle with rsp_ready=1: push, DRIVE, RESP, handshake.
  task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [3:0] tag,
                         input logic [15:0] exp_data, input logic exp_err);
    rsp_ready = 1'b1;
    set_cmd(a, b, sel, tag);
    tick;
    cmd_valid = 1'b0;
    tick;
    check({name, "_en"}, alu_en, 1);
    tick;
    check({name, "_valid"}, rsp_valid, 1);
    check({name, "_data"}, rsp_data, exp_data);
    check({name, "_tag"}, rsp_tag, tag);
    check({name, "_err"}, rsp_err, exp_err);
    tick;
    check({name, "_done"}, {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_tag;
    int stale;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_outs", {alu_en, rsp_valid, busy, rsp_err, cmd_count}, 0);
    check("rst_data", {alu_a, alu_b, alu_sel, rsp_data, rsp_tag}, 0);
    rst_n = 1'b1;
    tick;

    // ADD 200+100, response held until rsp_ready
    set_cmd(8'd200, 8'd100, 4'd0, 4'd1);
    tick;
    cmd_valid = 1'b0;
    check("add_k_en", alu_en, 0);
    check("add_k_cnt", cmd_count, 1);
    check("add_k_busy", busy, 1);
    tick;
    check("add_drive", {alu_en, rsp_valid, alu_a, alu_b, alu_sel}, {1'b1, 1'b0, 8'd200, 8'd100, 4'd0});
    check("add_drive_cnt", cmd_count, 0);
    tick;
    check("add_rsp", {alu_en, rsp_valid, rsp_data, rsp_tag, rsp_err}, {1'b0, 1'b1, 16'h012C, 4'd1, 1'b0});
    tick;
    check("add_hold", {rsp_valid, rsp_data, rsp_tag, alu_en}, {1'b1, 16'h012C, 4'd1, 1'b0});
    rsp_ready = 1'b1;
    tick;
    check("add_done", {rsp_valid, busy}, 2'b00);

    // MUL then SUB back to back
    set_cmd(8'd255, 8'd255, 4'd2, 4'd2);
    tick;
    set_cmd(8'd5, 8'd10, 4'd1, 4'd3);
    tick;
    cmd_valid = 1'b0;
    check("b2b_mul_en", {alu_en, alu_sel, cmd_count}, {1'b1, 4'd2, 3'd1});
    tick;
    check("b2b_mul_rsp", {rsp_valid, rsp_data, rsp_tag}, {1'b1, 16'hFE01, 4'd2});
    tick;
    check("b2b_gap", {rsp_valid, alu_en, alu_sel}, {1'b0, 1'b1, 4'd1});
    tick;
    check("b2b_sub_rsp", {rsp_valid, rsp_data, rsp_tag}, {1'b1, 16'hFFFB, 4'd3});
    tick;
    check("b2b_done", {rsp_valid, busy}, 2'b00);

    // divide / mod by zero and a legal divide
    run_one("div0", 8'd7, 8'd0, 4'd3, 4'd9, 16'h0000, 1'b1);
    run_one("mod0", 8'd7, 8'd0, 4'd15, 4'd10, 16'h0000, 1'b1);
    run_one("div", 8'd7, 8'd2, 4'd3, 4'd11, 16'h0003, 1'b0);
    run_one("mod", 8'd7, 8'd3, 4'd15, 4'd12, 16'h0001, 1'b0);

    // stall: six commands, FIFO fills, sixth held
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(8'(i), 8'd10, 4'd0, 4'(i));
      tick;
    end
    set_cmd(8'd5, 8'd10, 4'd0, 4'd5);
    check("full_ready", cmd_ready, 0);
    check("full_cnt", cmd_count, 4);
    check("full_rsp", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd0, 16'd10});
    tick;
    tick;
    check("stall_hold", {rsp_valid, rsp_tag, rsp_data, rsp_err}, {1'b1, 4'd0, 16'd10, 1'b0});
    check("stall_cnt", {cmd_ready, cmd_count}, {1'b0, 3'd4});
    rsp_ready = 1'b1;
    tick;
    check("full_pop", {cmd_count, cmd_ready, rsp_valid, alu_en}, {3'd3, 1'b1, 1'b0, 1'b1});
    tick;
    cmd_valid = 1'b0;
    check("late_push", {cmd_count, rsp_valid, rsp_tag, rsp_data}, {3'd4, 1'b1, 4'd1, 16'd11});
    exp_tag = 2;
    for (int cyc = 0; cyc < 40 && exp_tag < 6; cyc++) begin
      tick;
      if (rsp_valid) begin
        check("order_tag", rsp_tag, 32'(exp_tag));
        check("order_data", rsp_data, 32'(exp_tag + 10));
        exp_tag++;
      end
    end
    check("order_all", exp_tag, 6);
    tick;
    check("drain", {cmd_count, busy, rsp_valid}, 0);

    // reset during DRIVE with three entries queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(8'd20, 8'(i), 4'd0, 4'(i));
      tick;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    check("pre_rst", {alu_en, cmd_count}, {1'b1, 3'd3});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {alu_en, rsp_valid, busy, cmd_count, rsp_err}, 0);
    check("async_rst_data", {alu_a, alu_b, alu_sel, rsp_data, rsp_tag}, 0);
    check("async_rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid || alu_en || busy) stale++;
    end
    check("no_stale", stale, 0);
    run_one("post_rst", 8'd1, 8'd1, 4'd0, 4'd7, 16'h0002, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
